// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the
// datapath writeback (A) and the load/debug path (B); registered output stage.
module regfile_write_arbiter #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             enabled,
  output logic [NREGS-1:0] addressed,
  output logic [WIDTH-1:0] write,
  output logic             last_grant,
  output logic             addr_err,
  output logic [15:0]      wr_count
);

  localparam int unsigned CW = 16;

  logic             grant_a_c;
  logic             grant_b_c;
  logic             xfer_c;
  logic [AW-1:0]    sel_addr_c;
  logic [WIDTH-1:0] sel_data_c;
  logic             in_range_c;
  logic             wr_en_c;

  // Both valid: the side that did not win last time gets the port.
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (!hold) begin
      grant_a_c = a_valid && (!b_valid || last_grant);
      grant_b_c = b_valid && (!a_valid || !last_grant);
    end
  end

  assign a_ready = grant_a_c;
  assign b_ready = grant_b_c;

  always_comb begin
    xfer_c     = grant_a_c || grant_b_c;
    sel_addr_c = grant_b_c ? b_addr : a_addr;
    sel_data_c = grant_b_c ? b_data : a_data;
    in_range_c = 32'(sel_addr_c) < NREGS;
    // R0 and out-of-range targets are accepted but never reach the bank.
    wr_en_c    = xfer_c && in_range_c && (sel_addr_c != AW'(0));
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      enabled    <= 1'b0;
      addressed  <= '0;
      write      <= '0;
      last_grant <= 1'b1;
      addr_err   <= 1'b0;
      wr_count   <= '0;
    end else begin
      enabled   <= wr_en_c;
      addressed <= wr_en_c ? (NREGS'(1) << sel_addr_c) : '0;
      if (xfer_c) begin
        write      <= sel_data_c;
        last_grant <= grant_b_c;
      end
      if (xfer_c && !in_range_c) begin
        addr_err <= 1'b1;
      end
      if (wr_en_c) begin
        wr_count <= wr_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter with a 16-entry bank model.
module tb_regfile_write_arbiter;

  localparam int unsigned NREGS = 16;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;

  logic             CLK = 1'b0;
  logic             reset_n = 1'b0;
  logic             hold = 1'b0;
  logic             a_valid = 1'b0;
  logic [AW-1:0]    a_addr = '0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_ready;
  logic             b_valid = 1'b0;
  logic [AW-1:0]    b_addr = '0;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_ready;
  logic             enabled;
  logic [NREGS-1:0] addressed;
  logic [WIDTH-1:0] write;
  logic             last_grant;
  logic             addr_err;
  logic [15:0]      wr_count;

  regfile_write_arbiter #(.NREGS(NREGS), .WIDTH(WIDTH), .AW(AW)) dut (
    .CLK(CLK), .reset_n(reset_n), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .enabled(enabled), .addressed(addressed), .write(write),
    .last_grant(last_grant), .addr_err(addr_err), .wr_count(wr_count)
  );

  always #5 CLK = ~CLK;

  // Bank of registers driven by the arbiter outputs.
  logic [WIDTH-1:0] bank [NREGS];
  always @(posedge CLK) begin
    if (enabled) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        if (addressed[r]) bank[r] <= write;
      end
    end
  end

  typedef struct {
    logic        hold;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ear;
    logic        ebr;
    logic        een;
    logic [15:0] eaddr;
    logic [31:0] ewr;
    logic        elg;
    logic        eerr;
    logic [15:0] ecnt;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic h, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    hold = h; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic check_outs(input string tag, input logic en, input logic [15:0] ad,
                            input logic [31:0] wr, input logic lg, input logic er,
                            input logic [15:0] cnt);
    check({tag, ".enabled"}, 32'(enabled), 32'(en));
    check({tag, ".addressed"}, 32'(addressed), 32'(ad));
    check({tag, ".write"}, write, wr);
    check({tag, ".last_grant"}, 32'(last_grant), 32'(lg));
    check({tag, ".addr_err"}, 32'(addr_err), 32'(er));
    check({tag, ".wr_count"}, 32'(wr_count), 32'(cnt));
  endtask

  vec_t vecs [17];

  initial begin
    // hold av aa ad bv ba bd | ar br en addressed write lg err cnt
    vecs[0]  = '{0,1,3,32'hFFFF_1111,0,0,0,            1,0,1,16'h0008,32'hFFFF_1111,0,0,1};
    vecs[1]  = '{0,0,0,0,1,4,32'h0000_0044,            0,1,1,16'h0010,32'h0000_0044,1,0,2};
    vecs[2]  = '{0,1,1,32'h0000_0001,1,2,32'h0001_0001,1,0,1,16'h0002,32'h0000_0001,0,0,3};
    vecs[3]  = '{0,1,1,32'h0000_0001,1,2,32'h0001_0001,0,1,1,16'h0004,32'h0001_0001,1,0,4};
    vecs[4]  = '{0,1,1,32'h0000_0001,1,2,32'h0001_0001,1,0,1,16'h0002,32'h0000_0001,0,0,5};
    vecs[5]  = '{0,1,1,32'h0000_0001,1,2,32'h0001_0001,0,1,1,16'h0004,32'h0001_0001,1,0,6};
    vecs[6]  = '{0,0,0,0,0,0,0,                        0,0,0,16'h0000,32'h0001_0001,1,0,6};
    vecs[7]  = '{0,0,0,0,1,0,32'hDEAD_0000,            0,1,0,16'h0000,32'hDEAD_0000,1,0,6};
    vecs[8]  = '{0,0,0,0,1,20,32'h2020_2020,           0,1,0,16'h0000,32'h2020_2020,1,1,6};
    vecs[9]  = '{0,1,15,32'h0000_000F,0,0,0,           1,0,1,16'h8000,32'h0000_000F,0,1,7};
    vecs[10] = '{1,1,1,32'h0000_00A1,1,2,32'h0000_00B2,0,0,0,16'h0000,32'h0000_000F,0,1,7};
    vecs[11] = '{1,1,1,32'h0000_00A1,1,2,32'h0000_00B2,0,0,0,16'h0000,32'h0000_000F,0,1,7};
    vecs[12] = '{1,1,1,32'h0000_00A1,1,2,32'h0000_00B2,0,0,0,16'h0000,32'h0000_000F,0,1,7};
    vecs[13] = '{0,1,1,32'h0000_00A1,1,2,32'h0000_00B2,0,1,1,16'h0004,32'h0000_00B2,1,1,8};
    vecs[14] = '{0,1,5,32'hF001_0001,0,0,0,            1,0,1,16'h0020,32'hF001_0001,0,1,9};
    vecs[15] = '{0,0,0,0,1,5,32'h0000_00AA,            0,1,1,16'h0020,32'h0000_00AA,1,1,10};
    vecs[16] = '{0,0,0,0,0,0,0,                        0,0,0,16'h0000,32'h0000_00AA,1,1,10};

    // Power-on reset values.
    #12;
    check_outs("reset", 0, 16'h0, 32'h0, 1, 0, 16'h0);
    @(negedge CLK); reset_n = 1'b1;

    // Put a write in flight, then assert reset mid-cycle while enabled=1.
    drive(0, 1, 5'd7, 32'h1234_5678, 0, 5'd0, 32'h0);
    @(posedge CLK); #1;
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("pre_reset.enabled", 32'(enabled), 32'h1);
    #2 reset_n = 1'b0;
    #1 check_outs("mid_reset", 0, 16'h0, 32'h0, 1, 0, 16'h0);
    @(posedge CLK); #1;
    check("mid_reset.bank7", 32'(bank[7] === 32'h1234_5678), 32'h0);
    @(negedge CLK); reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].hold, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      #1;
      check($sformatf("v%0d.a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
      check($sformatf("v%0d.b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
      @(posedge CLK); #1;
      check_outs($sformatf("v%0d", i), vecs[i].een, vecs[i].eaddr, vecs[i].ewr,
                 vecs[i].elg, vecs[i].eerr, vecs[i].ecnt);
    end
    @(posedge CLK); #1;
    check("order.bank5", bank[5], 32'h0000_00AA);

    // Counter wrap: 65525 more issued writes bring 10 to 0xFFFF.
    @(negedge CLK);
    drive(0, 1, 5'd1, 32'h5555_0000, 0, 5'd0, 32'h0);
    for (int n = 0; n < 65525; n++) @(posedge CLK);
    #1 check("wrap.ffff", 32'(wr_count), 32'h0000_FFFF);
    @(posedge CLK); #1;
    check("wrap.zero", 32'(wr_count), 32'h0);
    check("wrap.enabled", 32'(enabled), 32'h1);
    @(negedge CLK);
    drive(0, 1, 5'd0, 32'h0000_0BAD, 0, 5'd0, 32'h0);
    @(posedge CLK); #1;
    check("r0.count", 32'(wr_count), 32'h0);
    check("r0.enabled", 32'(enabled), 32'h0);
    check("r0.write", write, 32'h0000_0BAD);
    @(negedge CLK);
    drive(0, 1, 5'd2, 32'h0000_0002, 0, 5'd0, 32'h0);
    @(posedge CLK); #1;
    check("post_wrap.count", 32'(wr_count), 32'h1);
    @(negedge CLK);
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single write port of the register bank between two requesters:
  - requester A: datapath writeback;
  - requester B: load/debug write path.
- Each cycle, at most one write is granted using valid/ready handshakes and round-robin arbitration.
- The accepted write is registered and driven to the bank as a one-hot `addressed` vector, an `enabled` strobe and `write` data.
- It sits between the writeback logic and the bank of `register` instances, whose `enabled`/`addressed`/`write` inputs it drives.

## Interface

Parameters:
- `NREGS`, 32, number of registers in the bank (`addressed` width).
- `WIDTH`, 32, data width.
- `AW`, 5, address width; `NREGS` ≤ 2^`AW`.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hold`  in  1  stall; while high no grant is issued.
- `a_valid`  in  1  A has a write pending.
- `a_addr`  in  AW  A target register.
- `a_data`  in  WIDTH  A write data.
- `a_ready`  out  1  A granted this cycle (combinational).
- `b_valid`, `b_addr`, `b_data`, `b_ready`  same as A, for requester B.
- `enabled`  out  1  registered write strobe to the bank.
- `addressed`  out  NREGS  registered one-hot register select.
- `write`  out  WIDTH  registered write data.
- `last_grant`  out  1  0 = A won last grant, 1 = B.
- `addr_err`  out  1  sticky; set on any accepted address ≥ `NREGS`.
- `wr_count`  out  16  count of writes actually issued to the bank (`enabled` pulses).

## Operation

- **Handshake:**
  - A transfer occurs on a rising edge with `x_valid && x_ready`.
  - `x_ready` depends only on the current `hold`, `a_valid`, `b_valid` and `last_grant`.
  - A requester holds addr/data stable until its transfer occurs.
- **Arbitration (when `hold`=0):**
  - Only A valid → A granted.
  - Only B valid → B granted.
  - Both valid → the side ≠ `last_grant` is granted.
  - Neither valid → no grant.
  - Never both ready in the same cycle.
  - `hold`=1 → `a_ready`=`b_ready`=0, and `last_grant` is unchanged.
- **`last_grant`:** updates to the granted side on every transfer, including single-requester grants.
- **Output stage (loaded every edge):**
  - Transfer with addr in 1..`NREGS`-1 → `enabled`=1, `addressed`=1<<addr, `write`=data.
  - Transfer to addr 0 → accepted but suppressed: `enabled`=0, `addressed`=0; `write` takes the data. R0 is never written.
  - Transfer to addr ≥ `NREGS` → accepted, suppressed as for addr 0, and `addr_err` set.
  - No transfer → `enabled`=0, `addressed`=0, `write` holds its value.
- **Counter:** `wr_count` increments on each edge where the output stage loads `enabled`=1, and wraps from 0xFFFF to 0.
- **Ordering:** grants are serialized, so two writes to the same register land in grant order; the later grant wins.

## Timing

- **Reset** (async assert, sync release behaviour irrelevant to outputs): `enabled`=0, `addressed`=0, `write`=0, `last_grant`=1 (so A wins the first conflict), `addr_err`=0, `wr_count`=0.
- **Latency:**
  - Transfer on edge N → `enabled`/`addressed`/`write` valid after edge N.
  - The bank latches on edge N+1.
  - Bank `read` reflects the data after N+1.
- **Throughput:** one write per cycle. Under continuous dual requests, grants alternate A,B,A,B.
- **Reset mid-operation:** an in-flight output-stage write is dropped (`enabled` forced 0 immediately), and no bank write occurs on the next edge.
- **`hold` rising while both are valid:** no transfer that cycle. The output stage goes idle the next edge. Arbitration resumes from the unchanged `last_grant`.
- **Simultaneous `hold` deassert and new requests:** a grant is issued in the same cycle `hold` falls.

## Test plan

- **Reset:** assert `reset_n`=0 mid-cycle with `enabled`=1 → all outputs 0 immediately, `last_grant`=1. Then release and A-only write addr 3, data 0xFFFF_1111 → `a_ready`=1, next cycle `enabled`=1, `addressed`=0x0000_0008, `write`=0xFFFF_1111, `wr_count`=1.
- **Conflict:** both valid for 4 cycles (A: addr 1, 0x0000_0001; B: addr 2, 0x0001_0001) → grant sequence A,B,A,B, `addressed` 0x2,0x4,0x2,0x4, `wr_count`=4.
- **Zero/out-of-range:** with `NREGS`=16, B writes addr 0 → accepted, `enabled`=0, `addr_err` stays 0. B then writes addr 20 → accepted, `enabled`=0, `addr_err`=1 until reset.
- **Hold:** `hold`=1 with both valid for 3 cycles → both ready 0, `enabled`=0, `last_grant` unchanged. On `hold`=0, the side ≠ `last_grant` is granted that cycle.
- **Same-address ordering:** A then B both target addr 5 (0xF001_0001 then 0x0000_00AA) → the bank register-5 `read` ends at 0x0000_00AA.
- **Counter wrap:** preload via 65 536 issued writes → `wr_count` = 0 after wrap. Suppressed writes (addr 0) never increment it.
